// File: rtl/dac_serial_multi.sv
// Multi-channel serial DAC driver. NUM_CH data lines shift in lock-step under one
// shared active-low sync frame; per-channel words come in through a one-deep shadow register.
module dac_serial_multi #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] load_data,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic                     mode,
    output logic                     sync,
    output logic [NUM_CH-1:0]        dout,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int TOT_W = NUM_CH * DATA_W;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TOT_W-1:0]   shadow_q, shadow_d;
    logic [TOT_W-1:0]   shift_q, shift_d;
    logic               pending_q, pending_d;
    logic               load_ready_q, load_ready_d;
    logic               sync_q, sync_d;
    logic [NUM_CH-1:0]  dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;

    // The shift register holds the bits still to be sent after the one on dout,
    // so its top bit is always the next bit out.
    logic [NUM_CH-1:0]  shadow_msb, shift_msb;
    logic [TOT_W-1:0]   shadow_adv, shift_adv;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign shadow_msb[gi] = shadow_q[gi*DATA_W + DATA_W-1];
        assign shift_msb[gi]  = shift_q[gi*DATA_W + DATA_W-1];
        assign shadow_adv[gi*DATA_W +: DATA_W] = {shadow_q[gi*DATA_W +: DATA_W-1], 1'b0};
        assign shift_adv[gi*DATA_W +: DATA_W]  = {shift_q[gi*DATA_W +: DATA_W-1], 1'b0};
    end

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shadow_d     = shadow_q;
        shift_d      = shift_q;
        pending_d    = pending_q;
        sync_d       = sync_q;
        dout_d       = dout_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sync_d = 1'b1;
                dout_d = '0;
                if (pending_q || mode) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end
            end
            ST_GAP: begin
                sync_d = 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    shift_d   = shadow_adv;
                    dout_d    = shadow_msb;
                    pending_d = 1'b0;
                    sync_d    = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    sync_d       = 1'b1;
                    dout_d       = '0;
                    frame_done_d = 1'b1;
                    if (mode || pending_q) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    shift_d   = shift_adv;
                    dout_d    = shift_msb;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept only while the shadow is empty; a consume on the same edge cannot collide.
        if (load_valid && load_ready_q) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end

        load_ready_d = ~pending_d;
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shadow_q     <= '0;
            shift_q      <= '0;
            pending_q    <= 1'b0;
            load_ready_q <= 1'b1;
            sync_q       <= 1'b1;
            dout_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shadow_q     <= shadow_d;
            shift_q      <= shift_d;
            pending_q    <= pending_d;
            load_ready_q <= load_ready_d;
            sync_q       <= sync_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign sync       = sync_q;
    assign dout       = dout_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dac_serial_multi.sv
// Directed bench for dac_serial_multi (2 channels, 16-bit frames, 2-cycle gap).
// Status word per sample: {load_ready, sync, dout[1], dout[0], frame_done, busy}.
module tb_dac_serial_multi;

    localparam int NUM_CH     = 2;
    localparam int DATA_W     = 16;
    localparam int GAP_CYCLES = 2;

    localparam logic [5:0] ST_IDLE_EXP = 6'b1_1_00_0_0;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [NUM_CH*DATA_W-1:0] load_data = '0;
    logic                     load_valid = 1'b0;
    logic                     load_ready;
    logic                     mode = 1'b0;
    logic                     sync;
    logic [NUM_CH-1:0]        dout;
    logic                     busy;
    logic                     frame_done;
    logic [5:0]               status;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign status = {load_ready, sync, dout, frame_done, busy};

    dac_serial_multi #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_data (load_data),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .mode      (mode),
        .sync      (sync),
        .dout      (dout),
        .busy      (busy),
        .frame_done(frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (status !== ST_IDLE_EXP) begin
                tests_failed++;
                $display("FAIL reset c=%0d status=%b expected=%b", c, status, ST_IDLE_EXP);
            end
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (status !== ST_IDLE_EXP) begin
            tests_failed++;
            $display("FAIL reset_release status=%b expected=%b", status, ST_IDLE_EXP);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_one_shot(input logic [15:0] w0, input logic [15:0] w1, input string tag);
        logic [5:0] exp;
        mode       = 1'b0;
        load_data  = {w1, w0};
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tests_run++;
        if (status !== 6'b0_1_00_0_0) begin
            tests_failed++;
            $display("FAIL %s accept status=%b expected=%b", tag, status, 6'b0_1_00_0_0);
        end
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c < 3)        exp = 6'b0_1_00_0_1;
            else if (c <= 18) exp = {1'b1, 1'b0, w1[18-c], w0[18-c], 1'b0, 1'b1};
            else if (c == 19) exp = 6'b1_1_00_1_0;
            else              exp = ST_IDLE_EXP;
            tests_run++;
            if (status !== exp) begin
                tests_failed++;
                $display("FAIL %s c=%0d status=%b expected=%b", tag, c, status, exp);
            end
        end
        $display("[TB] %s frame %h/%h done", tag, w0, w1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a0, a1, b0, b1;
        logic [5:0]  exp;
        a0 = 16'hF00F; a1 = 16'h0FF0;
        b0 = 16'h5A5A; b1 = 16'hC3C3;
        mode       = 1'b0;
        load_data  = {a1, a0};
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= 38; c++) begin
            if (c == 8) begin
                load_data  = {b1, b0};
                load_valid = 1'b1;
            end
            tick();
            load_valid = 1'b0;
            if (c < 3)        exp = 6'b0_1_00_0_1;
            else if (c <= 18) exp = {(c < 8), 1'b0, a1[18-c], a0[18-c], 1'b0, 1'b1};
            else if (c == 19) exp = 6'b0_1_00_1_1;
            else if (c == 20) exp = 6'b0_1_00_0_1;
            else if (c <= 36) exp = {1'b1, 1'b0, b1[36-c], b0[36-c], 1'b0, 1'b1};
            else if (c == 37) exp = 6'b1_1_00_1_0;
            else              exp = ST_IDLE_EXP;
            tests_run++;
            if (status !== exp) begin
                tests_failed++;
                $display("FAIL back_to_back c=%0d status=%b expected=%b", c, status, exp);
            end
        end
        $display("[TB] back_to_back frames done");
    endtask

    task automatic test_continuous();
        logic [15:0] w0, w1;
        logic [5:0]  exp;
        int          rel;
        w0 = 16'h8001; w1 = 16'h7FFE;
        mode       = 1'b0;
        load_data  = {w1, w0};
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        mode       = 1'b1;
        for (int c = 1; c <= 55; c++) begin
            tick();
            if (c < 3) begin
                exp = 6'b0_1_00_0_1;
            end else begin
                rel = (c - 3) % 18;
                if (rel < 16)       exp = {1'b1, 1'b0, w1[15-rel], w0[15-rel], 1'b0, 1'b1};
                else if (rel == 16) exp = 6'b1_1_00_1_1;
                else                exp = 6'b1_1_00_0_1;
            end
            tests_run++;
            if (status !== exp) begin
                tests_failed++;
                $display("FAIL continuous c=%0d status=%b expected=%b", c, status, exp);
            end
        end
        mode = 1'b0;
        repeat (21) tick();
        tests_run++;
        if (status !== ST_IDLE_EXP) begin
            tests_failed++;
            $display("FAIL continuous_stop status=%b expected=%b", status, ST_IDLE_EXP);
        end
        $display("[TB] continuous three frames done");
    endtask

    task automatic test_mode_switch();
        logic [15:0] w0, w1;
        logic [5:0]  exp;
        w0 = 16'h1111; w1 = 16'hEEEE;
        mode       = 1'b0;
        load_data  = {w1, w0};
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        mode       = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            tick();
            if (c == 10) mode = 1'b0;
            if (c < 3)        exp = 6'b0_1_00_0_1;
            else if (c <= 18) exp = {1'b1, 1'b0, w1[18-c], w0[18-c], 1'b0, 1'b1};
            else if (c == 19) exp = 6'b1_1_00_1_0;
            else              exp = ST_IDLE_EXP;
            tests_run++;
            if (status !== exp) begin
                tests_failed++;
                $display("FAIL mode_switch c=%0d status=%b expected=%b", c, status, exp);
            end
        end
        $display("[TB] mode_switch done");
    endtask

    task automatic test_reset_midframe();
        mode       = 1'b0;
        load_data  = {16'hFFFF, 16'hFFFF};
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (10) tick();
        tests_run++;
        if (status !== 6'b1_0_11_0_1) begin
            tests_failed++;
            $display("FAIL midframe_bit7 status=%b expected=%b", status, 6'b1_0_11_0_1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (status !== ST_IDLE_EXP) begin
            tests_failed++;
            $display("FAIL midframe_reset status=%b expected=%b", status, ST_IDLE_EXP);
        end
        tick();
        tests_run++;
        if (status !== ST_IDLE_EXP) begin
            tests_failed++;
            $display("FAIL midframe_after status=%b expected=%b", status, ST_IDLE_EXP);
        end
        $display("[TB] reset_midframe abort done");
        test_one_shot(16'hC001, 16'h3FFE, "after_reset");
    endtask

    initial begin
        test_reset();
        test_one_shot(16'hA5C3, 16'h1234, "one_shot");
        test_back_to_back();
        test_continuous();
        test_mode_switch();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
